// File: rtl/mpu_bus_master_if.sv
// Purpose: groups the requester handshake and the MPU-side control/address
//          signals of mpu_bus_master into one bundle.
// Signals:
//   requester side : req, wr, be[1:0], addr, wdata, ack, rdata, busy
//                    (+ addr_inc when MPU_BUS_AUTOINC_EN is defined)
//   MPU side       : _mpu_en, _mpu_rd, _mpu_wr, _mpu_be[1:0], mpu_addr
//   The bidirectional mpu_data bus is a plain inout port of the master so
//   that tri-state resolution stays on an ordinary net.
// Modports: master = the bus master block, slave = requester / device side.
// Optional macro: MPU_BUS_AUTOINC_EN adds addr_inc.
interface mpu_bus_master_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  req;
  logic                  wr;
  logic [1:0]            be;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
`ifdef MPU_BUS_AUTOINC_EN
  logic                  addr_inc;
`endif
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;
  logic                  _mpu_en;
  logic                  _mpu_rd;
  logic                  _mpu_wr;
  logic [1:0]            _mpu_be;
  logic [ADDR_WIDTH-1:0] mpu_addr;

  modport master (
    input  req, wr, be, addr, wdata,
`ifdef MPU_BUS_AUTOINC_EN
    input  addr_inc,
`endif
    output ack, rdata, busy, _mpu_en, _mpu_rd, _mpu_wr, _mpu_be, mpu_addr
  );

  modport slave (
    output req, wr, be, addr, wdata,
`ifdef MPU_BUS_AUTOINC_EN
    output addr_inc,
`endif
    input  ack, rdata, busy, _mpu_en, _mpu_rd, _mpu_wr, _mpu_be, mpu_addr
  );
endinterface

// File: rtl/mpu_bus_master.sv
// Purpose: single-transaction master for an asynchronous MPU-style bus.
//          Each request runs SETUP -> STROBE -> HOLD with programmable
//          lengths, then returns to IDLE with a one-cycle ack.
// Ports:
//   clk      : system clock, rising edge
//   reset    : synchronous, active-high
//   bus      : mpu_bus_master_if.master (request handshake + MPU control)
//   mpu_data : bidirectional data bus, driven only during write cycles
// Optional macro: MPU_BUS_AUTOINC_EN adds an address pointer selected by
//   bus.addr_inc; it is set to (used address + 1) after every completed
//   transaction and clears on reset.
//
// state  | meaning
// IDLE   | waiting for req; ack is high in the first IDLE cycle after HOLD
// SETUP  | enable, address and byte enables valid, strobes high
// STROBE | read or write strobe low
// HOLD   | strobes high, enable/address/data still driven
module mpu_bus_master #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int SETUP_CYCLES  = 1,   // legal 1..15
  parameter int STROBE_CYCLES = 2,   // legal 1..15
  parameter int HOLD_CYCLES   = 1    // legal 1..15
) (
  input  logic                  clk,
  input  logic                  reset,
  mpu_bus_master_if.master      bus,
  inout  wire  [DATA_WIDTH-1:0] mpu_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;

  // One shared down-counter; each state is entered with (length - 1).
  localparam logic [3:0] LP_SETUP_LD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] LP_STROBE_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] LP_HOLD_LD   = 4'(HOLD_CYCLES - 1);

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic                  w_accept, w_done, w_rd_cap, w_wr_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_sel;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [1:0]            r_be_n;
  logic                  r_wr, r_en_n, r_rd_n, r_wr_n, r_drive, r_ack;

`ifdef MPU_BUS_AUTOINC_EN
  logic [ADDR_WIDTH-1:0] r_ptr;

  assign w_addr_sel = bus.addr_inc ? r_ptr : bus.addr;

  always_ff @(posedge clk) begin
    if (reset)       r_ptr <= '0;
    else if (w_done) r_ptr <= r_addr + ADDR_WIDTH'(1);
  end
`else
  assign w_addr_sel = bus.addr;
`endif

  assign w_accept = (r_state == ST_IDLE) && bus.req;
  assign w_done   = (r_state == ST_HOLD) && (r_cnt == 4'd0);
  assign w_rd_cap = (r_state == ST_STROBE) && (r_cnt == 4'd0) && !r_wr;
  // Direction that will be in effect after this edge.
  assign w_wr_nxt = w_accept ? bus.wr : r_wr;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (bus.req) begin
          w_state_nxt = ST_SETUP;
          w_cnt_nxt   = LP_SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_STROBE;
          w_cnt_nxt   = LP_STROBE_LD;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_STROBE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = LP_HOLD_LD;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_HOLD: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Bus controls are registered from the next state so the pins are
  // glitch-free and change exactly at state boundaries.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be_n  <= 2'b11;
      r_en_n  <= 1'b1;
      r_rd_n  <= 1'b1;
      r_wr_n  <= 1'b1;
      r_drive <= 1'b0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_wr    <= bus.wr;
        r_be_n  <= ~bus.be;
        r_addr  <= w_addr_sel;
        r_wdata <= bus.wdata;
      end
      r_en_n  <= (w_state_nxt == ST_IDLE);
      r_rd_n  <= !((w_state_nxt == ST_STROBE) && !w_wr_nxt);
      r_wr_n  <= !((w_state_nxt == ST_STROBE) && w_wr_nxt);
      r_drive <= (w_state_nxt != ST_IDLE) && w_wr_nxt;
      r_ack   <= w_done;
      if (w_rd_cap) r_rdata <= mpu_data;
    end
  end

  assign mpu_data     = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};
  assign bus.ack      = r_ack;
  assign bus.rdata    = r_rdata;
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus._mpu_en  = r_en_n;
  assign bus._mpu_rd  = r_rd_n;
  assign bus._mpu_wr  = r_wr_n;
  assign bus._mpu_be  = r_be_n;
  assign bus.mpu_addr = r_addr;

endmodule

// File: tb/tb_mpu_bus_master.sv
// Bench for mpu_bus_master: two instances (default timing and 3/1/2 timing)
// share one stimulus stream; each has a timeline reference model that tracks
// the cycle index inside the current transaction.
`timescale 1ns/1ps
module tb_mpu_bus_master;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          s_req = 1'b0, s_wr = 1'b0, s_inc = 1'b0;
  logic [1:0]    s_be = 2'b00;
  logic [AW-1:0] s_addr = '0;
  logic [DW-1:0] s_wdata = '0;
  bit            rd_force = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int S   = (g == 0) ? 1 : 3;
    localparam int T   = (g == 0) ? 2 : 1;
    localparam int H   = (g == 0) ? 1 : 2;
    localparam int TOT = S + T + H;

    mpu_bus_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    wire [DW-1:0] mpu_data;

    // Model: m_k = index of the current transaction cycle (1..TOT), 0 = idle.
    int            m_k = 0;
    bit            m_wr = 1'b0, m_ack = 1'b0, m_live = 1'b0;
    logic [1:0]    m_be = 2'b00;
    logic [AW-1:0] m_addr = '0, m_ptr = '0;
    logic [DW-1:0] m_wdata = '0, m_rdv = '0, m_rdata = '0;

    assign bus.req   = s_req;
    assign bus.wr    = s_wr;
    assign bus.be    = s_be;
    assign bus.addr  = s_addr;
    assign bus.wdata = s_wdata;
`ifdef MPU_BUS_AUTOINC_EN
    assign bus.addr_inc = s_inc;
`endif
    // Device model returns m_rdv for the whole duration of a read.
    assign mpu_data = (m_k != 0 && !m_wr) ? m_rdv : {DW{1'bz}};

    mpu_bus_master #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H)
    ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .mpu_data(mpu_data)
    );

    always @(posedge clk) begin
      if (reset) begin
        m_k = 0; m_ack = 1'b0; m_wr = 1'b0; m_be = 2'b00;
        m_addr = '0; m_ptr = '0; m_rdata = '0; m_live = 1'b1;
      end else begin
        m_ack = 1'b0;
        if (m_k == S + T && !m_wr) m_rdata = m_rdv;
        if (m_k == TOT) begin
          m_k = 0; m_ack = 1'b1; m_ptr = m_addr + 16'd1;
        end else if (m_k != 0) begin
          m_k++;
        end else if (s_req) begin
          m_k = 1; m_wr = s_wr; m_be = s_be; m_wdata = s_wdata;
`ifdef MPU_BUS_AUTOINC_EN
          m_addr = s_inc ? m_ptr : s_addr;
`else
          m_addr = s_addr;
`endif
          m_rdv = rd_force ? 16'h1234 : 16'($urandom);
        end
      end
    end

    always @(negedge clk) begin
      bit strb;
      if (m_live) begin
        strb = (m_k > S) && (m_k <= S + T);
        check_eq($sformatf("busy%0d", g), bus.busy, m_k != 0);
        check_eq($sformatf("ack%0d", g), bus.ack, m_ack);
        check_eq($sformatf("en_n%0d", g), bus._mpu_en, m_k == 0);
        check_eq($sformatf("rd_n%0d", g), bus._mpu_rd, !(strb && !m_wr));
        check_eq($sformatf("wr_n%0d", g), bus._mpu_wr, !(strb && m_wr));
        check_eq($sformatf("be_n%0d", g), bus._mpu_be, 2'(~m_be));
        check_eq($sformatf("maddr%0d", g), bus.mpu_addr, m_addr);
        check_eq($sformatf("rdata%0d", g), bus.rdata, m_rdata);
        if (m_k != 0 && m_wr) check_eq($sformatf("wdata%0d", g), mpu_data, m_wdata);
      end
    end
  end

  // Per-transaction observations of the directed runs.
  int            lat0, lat1, st0, st1, dcnt0;
  logic [7:0]    en_v0, wr_v0, rd_v0;
  logic [AW-1:0] addr_first0;
  logic [1:0]    be_first0;

  task automatic wait_idle();
    bit ok = 1'b0;
    s_req = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = !g_inst[0].bus.busy && !g_inst[1].bus.busy;
    end
    check_eq("idle_reached", ok, 1'b1);
  endtask

  // Issue one request pulse from idle and observe 12 cycles.
  task automatic run_one(input bit wr, input logic [1:0] be, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input bit inc);
    s_wr = wr; s_be = be; s_addr = addr; s_wdata = wdata; s_inc = inc; s_req = 1'b1;
    lat0 = 0; lat1 = 0; st0 = 0; st1 = 0; dcnt0 = 0;
    en_v0 = 8'hFF; wr_v0 = 8'hFF; rd_v0 = 8'hFF;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) begin
        s_req = 1'b0;
        addr_first0 = g_inst[0].bus.mpu_addr;
        be_first0   = g_inst[0].bus._mpu_be;
      end
      // Changes while busy must be ignored.
      s_addr = 16'($urandom); s_wdata = 16'($urandom); s_wr = 1'($urandom); s_be = 2'($urandom);
      if (g_inst[0].bus.ack && lat0 == 0) lat0 = n;
      if (g_inst[1].bus.ack && lat1 == 0) lat1 = n;
      if (!g_inst[0].bus._mpu_rd || !g_inst[0].bus._mpu_wr) st0++;
      if (!g_inst[1].bus._mpu_rd || !g_inst[1].bus._mpu_wr) st1++;
      if (n <= 4 && g_inst[0].mpu_data == wdata) dcnt0++;
      if (n <= 7) begin
        en_v0[n] = g_inst[0].bus._mpu_en;
        wr_v0[n] = g_inst[0].bus._mpu_wr;
        rd_v0[n] = g_inst[0].bus._mpu_rd;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int acks;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", g_inst[0].bus.busy, 1'b0);
    check_eq("rst_en", g_inst[0].bus._mpu_en, 1'b1);
    check_eq("rst_rd", g_inst[0].bus._mpu_rd, 1'b1);
    check_eq("rst_wr", g_inst[0].bus._mpu_wr, 1'b1);
    check_eq("rst_be", g_inst[0].bus._mpu_be, 2'b11);
    check_eq("rst_addr", g_inst[0].bus.mpu_addr, 16'h0000);
    check_eq("rst_rdata", g_inst[0].bus.rdata, 16'h0000);
    check_eq("rst_ack", g_inst[0].bus.ack, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Default-timing write and 3/1/2 timing on the second instance.
    run_one(1'b1, 2'b11, 16'h0800, 16'hBEEF, 1'b0);
    check_eq("w_lat0", lat0, 5);
    check_eq("w_lat1", lat1, 7);
    check_eq("w_en_trace", en_v0, 8'b1110_0001);
    check_eq("w_wr_trace", wr_v0, 8'b1111_0011);
    check_eq("w_data_cycles", dcnt0, 4);
    check_eq("w_strobe0", st0, 2);
    check_eq("w_strobe1", st1, 1);
    check_eq("w_addr", addr_first0, 16'h0800);
    wait_idle();

    // Read with fixed device data, then a write must leave rdata alone.
    rd_force = 1'b1;
    run_one(1'b0, 2'b11, 16'h0010, 16'h0000, 1'b0);
    rd_force = 1'b0;
    check_eq("r_lat0", lat0, 5);
    check_eq("r_lat1", lat1, 7);
    check_eq("r_rd_trace", rd_v0, 8'b1111_0011);
    check_eq("r_strobe1", st1, 1);
    check_eq("r_rdata0", g_inst[0].bus.rdata, 16'h1234);
    check_eq("r_rdata1", g_inst[1].bus.rdata, 16'h1234);
    wait_idle();
    run_one(1'b1, 2'b01, 16'h0020, 16'h5555, 1'b0);
    check_eq("r_rdata_held", g_inst[0].bus.rdata, 16'h1234);
    wait_idle();

    // Empty byte enables still give a full cycle and an ack.
    run_one(1'b1, 2'b00, 16'h0030, 16'hA5A5, 1'b0);
    check_eq("be0_lat", lat0, 5);
    check_eq("be0_be_n", be_first0, 2'b11);
    wait_idle();

    // Back-to-back reads with req held through the ack cycle.
    s_wr = 1'b0; s_addr = 16'h0100; s_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = g_inst[0].bus.ack;
    end
    check_eq("b2b_first_ack", got, 1'b1);
    @(negedge clk);
    s_req = 1'b0;
    check_eq("b2b_busy", g_inst[0].bus.busy, 1'b1);
    check_eq("b2b_en", g_inst[0].bus._mpu_en, 1'b0);
    wait_idle();

    // Reset in the first STROBE cycle of a write aborts it.
    s_wr = 1'b1; s_be = 2'b11; s_addr = 16'h0200; s_wdata = 16'hCAFE; s_req = 1'b1;
    @(negedge clk);
    s_req = 1'b0;
    @(negedge clk);
    check_eq("abort_pre_wr", g_inst[0].bus._mpu_wr, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_busy", g_inst[0].bus.busy, 1'b0);
    check_eq("abort_en", g_inst[0].bus._mpu_en, 1'b1);
    check_eq("abort_wr", g_inst[0].bus._mpu_wr, 1'b1);
    check_eq("abort_rd", g_inst[0].bus._mpu_rd, 1'b1);
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      if (g_inst[0].bus.ack) acks++;
      @(negedge clk);
    end
    check_eq("abort_no_ack", acks, 0);

`ifdef MPU_BUS_AUTOINC_EN
    run_one(1'b1, 2'b11, 16'hFFFF, 16'h1111, 1'b0);
    wait_idle();
    run_one(1'b1, 2'b11, 16'h4444, 16'h2222, 1'b1);
    check_eq("inc_wrap_addr", addr_first0, 16'h0000);
    wait_idle();
`endif

    // Randomized traffic, including occasional resets, checked by the models.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      s_req   = ($urandom_range(0, 9) < 6);
      s_wr    = 1'($urandom);
      s_be    = 2'($urandom);
      s_addr  = 16'($urandom);
      s_wdata = 16'($urandom);
      s_inc   = ($urandom_range(0, 3) == 0);
      reset   = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
